// File: rtl/ps2_kb_decoder_if.sv
// PS/2 pin pair plus decoded key outputs shared by the board pins, ps2_kb_decoder and the game logic.
interface ps2_kb_decoder_if;
   logic       ps2c;
   logic       ps2d;
   logic [2:0] kb_out;
   logic       kb_valid;
   logic [7:0] scan_code;
   logic       frame_err;

   modport master (output ps2c, ps2d, input kb_out, kb_valid, scan_code, frame_err);
   modport slave  (input ps2c, ps2d, output kb_out, kb_valid, scan_code, frame_err);
endinterface

// File: rtl/ps2_kb_decoder.sv
// PS/2 keyboard receiver and arrow/WASD/space decoder feeding snake's kb_out.
// Optional odd-parity check on received frames: define PS2_PARITY_CHECK_EN.
module ps2_kb_decoder #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 12500
) (
   input  logic            clk,
   input  logic            clr,
   ps2_kb_decoder_if.slave bus
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;
   typedef enum logic [2:0] {K_NONE, K_UP, K_DOWN, K_LEFT, K_RIGHT, K_SPACE} key_t;

   // Pin vectors are ordered {ps2d, ps2c}.
   logic [1:0]    pin, sync1, sync2, filt;
   logic [FW-1:0] flt_cnt [2];
   logic          c_filt_q;
   logic          fall;

   assign pin = {bus.ps2d, bus.ps2c};

   // NOTE: every stage resets to 1, the idle bus level, so reset release never fabricates a fall edge.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1    <= '1;
         sync2    <= '1;
         filt     <= '1;
         c_filt_q <= 1'b1;
         for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
      end else begin
         sync1    <= pin;
         sync2    <= sync1;
         c_filt_q <= filt[0];
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               flt_cnt[i] <= '0;
            end else if (flt_cnt[i] == FW'(FILTER_LEN - 1)) begin
               filt[i]    <= sync2[i];
               flt_cnt[i] <= '0;
            end else begin
               flt_cnt[i] <= flt_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign fall = c_filt_q & ~filt[0];

   rx_state_t     state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          stop_ok;
   logic          byte_done;
   logic          byte_bad;
   logic [7:0]    byte_data;

   // A fall edge in the expiry cycle takes priority over the timeout.
   assign tmo_hit = (state != S_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC));

`ifdef PS2_PARITY_CHECK_EN
   logic par_ok;
   assign stop_ok = filt[1] && par_ok;
`else
   assign stop_ok = filt[1];
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         tmo_cnt   <= '0;
         byte_done <= 1'b0;
         byte_bad  <= 1'b0;
         byte_data <= '0;
`ifdef PS2_PARITY_CHECK_EN
         par_ok    <= 1'b0;
`endif
      end else begin
         byte_done <= 1'b0;
         byte_bad  <= 1'b0;
         if (state == S_IDLE || fall || tmo_hit) tmo_cnt <= '0;
         else                                    tmo_cnt <= tmo_cnt + 1'b1;

         if (fall) begin
            case (state)
               S_IDLE: begin
                  if (!filt[1]) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                  end
               end
               S_DATA: begin
                  shreg   <= {filt[1], shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= S_PARITY;
               end
               S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  par_ok <= ^{shreg, filt[1]};
`endif
                  state  <= S_STOP;
               end
               S_STOP: begin
                  state <= S_IDLE;
                  if (stop_ok) begin
                     byte_done <= 1'b1;
                     byte_data <= shreg;
                  end else begin
                     byte_bad  <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end else if (tmo_hit) begin
            state <= S_IDLE;
         end
      end
   end

   logic [7:0] scan_r;
   key_t       kb_out_r;
   key_t       key;
   logic       kb_valid_r;
   logic       frame_err_r;
   logic       ext;
   logic       brk;

   always_comb begin
      key = K_NONE;
      if (ext) begin
         case (byte_data)
            8'h75:   key = K_UP;
            8'h72:   key = K_DOWN;
            8'h6B:   key = K_LEFT;
            8'h74:   key = K_RIGHT;
            default: key = K_NONE;
         endcase
      end else begin
         case (byte_data)
            8'h1D:   key = K_UP;
            8'h1B:   key = K_DOWN;
            8'h1C:   key = K_LEFT;
            8'h23:   key = K_RIGHT;
            8'h29:   key = K_SPACE;
            default: key = K_NONE;
         endcase
      end
   end

   // Releases clear the prefix flags but never kb_out: the last direction is held.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         scan_r      <= '0;
         kb_out_r    <= K_NONE;
         kb_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
         ext         <= 1'b0;
         brk         <= 1'b0;
      end else begin
         kb_valid_r  <= 1'b0;
         frame_err_r <= byte_bad | tmo_hit;
         if (byte_done) begin
            scan_r <= byte_data;
            if (byte_data == 8'hE0) begin
               ext <= 1'b1;
            end else if (byte_data == 8'hF0) begin
               brk <= 1'b1;
            end else if (brk) begin
               brk <= 1'b0;
               ext <= 1'b0;
            end else begin
               ext <= 1'b0;
               if (key != K_NONE) begin
                  kb_out_r   <= key;
                  kb_valid_r <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.kb_out    = kb_out_r;
   assign bus.kb_valid  = kb_valid_r;
   assign bus.scan_code = scan_r;
   assign bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_ps2_kb_decoder.sv
// Self-checking bench for ps2_kb_decoder: directed scenarios plus random frames against a key-table model.
// Compile with PS2_PARITY_CHECK_EN defined to exercise the parity-checking build.
module tb_ps2_kb_decoder;
   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 12500;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_CHK = 1'b1;
`else
   localparam bit PAR_CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   ps2_kb_decoder_if bus ();

   ps2_kb_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulse monitor: counts strobes and flags overlaps or multi-cycle pulses.
   int   n_valid = 0;
   int   n_err   = 0;
   int   n_viol  = 0;
   logic prev_v  = 1'b0;
   logic prev_e  = 1'b0;
   always @(negedge clk) begin
      if (clr) begin
         prev_v = 1'b0;
         prev_e = 1'b0;
      end else begin
         if (bus.kb_valid === 1'b1)  n_valid++;
         if (bus.frame_err === 1'b1) n_err++;
         if (bus.kb_valid === 1'b1 && bus.frame_err === 1'b1) n_viol++;
         if ((bus.kb_valid === 1'b1 && prev_v) || (bus.frame_err === 1'b1 && prev_e)) n_viol++;
         prev_v = (bus.kb_valid === 1'b1);
         prev_e = (bus.frame_err === 1'b1);
      end
   end

   // Reference model: key tables indexed by scan byte plus prefix flags.
   logic [2:0] map_std [256];
   logic [2:0] map_ext [256];
   logic [2:0] m_kb    = 3'd0;
   logic [7:0] m_scan  = 8'h00;
   bit         m_ext   = 1'b0;
   bit         m_brk   = 1'b0;
   int         m_valid = 0;
   int         m_err   = 0;

   function automatic void model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      bit         good;
      logic [2:0] code;
      good = !bad_stop && !(PAR_CHK && bad_par);
      if (!good) begin
         m_err++;
         return;
      end
      m_scan = b;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (m_brk) begin
         m_brk = 1'b0;
         m_ext = 1'b0;
      end else begin
         code  = m_ext ? map_ext[b] : map_std[b];
         m_ext = 1'b0;
         if (code != 3'd0) begin
            m_kb = code;
            m_valid++;
         end
      end
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives n_bits of a frame (start, 8 data LSB-first, odd parity, stop); optionally probes stop-edge latency.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int half, input int n_bits, input bit chk_lat);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < n_bits; i++) begin
         bus.ps2d = bits[i];
         wait_cyc(half);
         bus.ps2c = 1'b0;
         if (chk_lat && i == 10) begin
            for (int c = 1; c <= FILTER_LEN + 5; c++) begin
               @(posedge clk);
               @(negedge clk);
               if (c == FILTER_LEN + 3) check("lat_valid_early", bus.kb_valid, 1'b0);
               if (c == FILTER_LEN + 4) begin
                  check("lat_valid_on", bus.kb_valid, 1'b1);
                  check("lat_scan_on", bus.scan_code, b);
               end
               if (c == FILTER_LEN + 5) check("lat_valid_off", bus.kb_valid, 1'b0);
            end
            wait_cyc(1);
         end else begin
            wait_cyc(half);
         end
         bus.ps2c = 1'b1;
      end
      bus.ps2d = 1'b1;
   endtask

   task automatic xfer(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop,
                       input int half, input bit chk_lat);
      send_frame(b, bad_par, bad_stop, half, 11, chk_lat);
      model_frame(b, bad_par, bad_stop);
      wait_cyc(20);
      check({tag, "_scan"},   bus.scan_code, m_scan);
      check({tag, "_kb"},     bus.kb_out,    m_kb);
      check({tag, "_nvalid"}, n_valid,       m_valid);
      check({tag, "_nerr"},   n_err,         m_err);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] std_codes [5];
      logic [7:0] ext_codes [4];
      logic [7:0] b;
      int         r;

      std_codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29};
      ext_codes = '{8'h75, 8'h72, 8'h6B, 8'h74};
      for (int i = 0; i < 256; i++) begin
         map_std[i] = 3'd0;
         map_ext[i] = 3'd0;
      end
      map_std[8'h1D] = 3'd1; map_std[8'h1B] = 3'd2; map_std[8'h1C] = 3'd3;
      map_std[8'h23] = 3'd4; map_std[8'h29] = 3'd5;
      map_ext[8'h75] = 3'd1; map_ext[8'h72] = 3'd2; map_ext[8'h6B] = 3'd3; map_ext[8'h74] = 3'd4;

      bus.ps2c = 1'b1;
      bus.ps2d = 1'b1;
      wait_cyc(5);
      @(negedge clk);
      check("rst_kb",    bus.kb_out,    3'd0);
      check("rst_valid", bus.kb_valid,  1'b0);
      check("rst_scan",  bus.scan_code, 8'h00);
      check("rst_err",   bus.frame_err, 1'b0);
      wait_cyc(1);
      clr = 1'b0;
      wait_cyc(20);

      // First make code, with exact output latency from the stop edge.
      xfer("up", 8'h1D, 1'b0, 1'b0, 20, 1'b1);

      // Extended make then extended break: one pulse, held direction.
      xfer("e0_a",  8'hE0, 1'b0, 1'b0, 20, 1'b0);
      xfer("left",  8'h6B, 1'b0, 1'b0, 20, 1'b0);
      xfer("e0_b",  8'hE0, 1'b0, 1'b0, 20, 1'b0);
      xfer("f0",    8'hF0, 1'b0, 1'b0, 20, 1'b0);
      xfer("rel",   8'h6B, 1'b0, 1'b0, 20, 1'b0);

      // Wrong parity bit: dropped only in the parity-checking build.
      xfer("badpar", 8'h1D, 1'b1, 1'b0, 20, 1'b0);

      // Partial frame then idle clock: timeout abort, then a clean frame.
      send_frame(8'h23, 1'b0, 1'b0, 20, 5, 1'b0);
      wait_cyc(TIMEOUT_CYC + 5);
      m_err++;
      check("tmo_nerr", n_err,         m_err);
      check("tmo_scan", bus.scan_code, m_scan);
      check("tmo_kb",   bus.kb_out,    m_kb);
      xfer("tmo_next", 8'h23, 1'b0, 1'b0, 20, 1'b0);

      // Short clock glitches with data low (looks like a start bit) must be filtered out.
      bus.ps2d = 1'b0;
      for (int g = 0; g < 4; g++) begin
         bus.ps2c = 1'b0;
         wait_cyc(3);
         bus.ps2c = 1'b1;
         wait_cyc(20);
      end
      bus.ps2d = 1'b1;
      wait_cyc(TIMEOUT_CYC / 4);
      check("glitch_nerr",   n_err,   m_err);
      check("glitch_nvalid", n_valid, m_valid);
      xfer("badstop", 8'h29, 1'b0, 1'b1, 20, 1'b0);

      // Reset during the 5th data bit, then a full frame.
      send_frame(8'h29, 1'b0, 1'b0, 20, 5, 1'b0);
      bus.ps2d = 1'b0;
      wait_cyc(20);
      bus.ps2c = 1'b0;
      wait_cyc(5);
      clr = 1'b1;
      @(negedge clk);
      check("clr_kb",    bus.kb_out,    3'd0);
      check("clr_valid", bus.kb_valid,  1'b0);
      check("clr_scan",  bus.scan_code, 8'h00);
      check("clr_err",   bus.frame_err, 1'b0);
      bus.ps2c = 1'b1;
      bus.ps2d = 1'b1;
      wait_cyc(30);
      clr    = 1'b0;
      m_kb   = 3'd0;
      m_scan = 8'h00;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      wait_cyc(20);
      check("clr_rel_nerr", n_err, m_err);
      xfer("after_clr", 8'h29, 1'b0, 1'b0, 20, 1'b0);

      // Random traffic: mapped codes, prefixes, arbitrary bytes, occasional bad frames.
      for (int i = 0; i < 24; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 3)      b = std_codes[$urandom_range(0, 4)];
         else if (r <= 5) b = ext_codes[$urandom_range(0, 3)];
         else if (r == 6) b = 8'hE0;
         else if (r == 7) b = 8'hF0;
         else             b = 8'($urandom_range(0, 255));
         xfer($sformatf("rnd%0d", i), b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
              $urandom_range(12, 30), 1'b0);
      end

      check("pulse_rules", n_viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/ps2_kb_decoder.md
# ps2_kb_decoder

PS/2 keyboard receiver and key decoder that produces the `kb_out` direction code consumed by `snake`. It deserialises device-to-host PS/2 frames on `ps2c`/`ps2d`, tracks the E0 (extended) and F0 (break) prefixes, and maps arrow, WASD and space make-codes to a held 3-bit code plus a one-cycle strobe. It sits between the board PS/2 pins and the game logic, and runs in the same `clk` domain as `snake`.

## Interface
- `FILTER_LEN`, 8: number of consecutive identical synchronised samples required before the filtered `ps2c`/`ps2d` change.
- `TIMEOUT_CYC`, 12500: number of idle `clk` cycles inside a frame before the frame is aborted (500 µs at 25 MHz).
- `clk`  in  1  system clock.
- `clr`  in  1  asynchronous, active-high reset.
- `ps2c`  in  1  PS/2 clock pin, asynchronous to `clk`.
- `ps2d`  in  1  PS/2 data pin, asynchronous to `clk`.
- `kb_out`  out  3  held key code: 0 none, 1 up, 2 down, 3 left, 4 right, 5 space.
- `kb_valid`  out  1  one-cycle strobe when `kb_out` is (re)loaded from a mapped make-code.
- `scan_code`  out  8  last good byte received, including prefix bytes.
- `frame_err`  out  1  one-cycle strobe when a frame is dropped.

## Operation
- **Input path:** 2-FF synchroniser on each pin, then a glitch filter. The filtered value changes only after `FILTER_LEN` consecutive equal samples. A fall edge is the cycle in which filtered `ps2c` goes 1→0.
- **Receiver FSM** (advances on fall edges only):
  - IDLE: if `ps2d`=0 go to DATA with the bit count at 0; if `ps2d`=1 ignore the edge and stay.
  - DATA: shift `ps2d` in LSB-first. After the 8th bit go to PARITY.
  - PARITY: capture the bit and go to STOP.
  - STOP: if the bit is 1 the byte is good, otherwise pulse `frame_err` and drop the byte. Return to IDLE in either case.
- **Timeout:** in any state other than IDLE, a counter runs and clears on every fall edge. When it reaches `TIMEOUT_CYC`, the FSM returns to IDLE, `frame_err` pulses and the partial byte is discarded. The prefix flags are kept.
- **Byte decoder** (acts on each good byte):
  - E0: set `ext`.
  - F0: set `brk`.
  - Any other byte with `brk`=1: release. Clear `brk` and `ext`; no output change.
  - Otherwise, with `ext`=1: 75→1, 72→2, 6B→3, 74→4.
  - Otherwise, with `ext`=0: 1D→1, 1B→2, 1C→3, 23→4, 29→5.
  - A mapped code loads `kb_out` and pulses `kb_valid`. An unmapped code leaves `kb_out` unchanged and does not pulse `kb_valid`.
  - `ext` clears after any non-prefix byte.
- Key releases never clear `kb_out`; the last direction is held. Typematic repeats re-pulse `kb_valid` even when the code is unchanged.
- `scan_code` loads on every good byte, prefixes included.

## Timing
- **Reset values:** `kb_out`=0, `kb_valid`=0, `scan_code`=8'h00, `frame_err`=0. FSM in IDLE, `ext`=`brk`=0, counters 0, filter outputs 1.
- **Latency:** the stop-bit fall edge is registered as byte-done in cycle N+1. `scan_code`, `kb_out`, `kb_valid` and the prefix flags update in cycle N+2. `frame_err` also asserts in cycle N+2 for a bad stop bit.
- **Timeout:** `frame_err` asserts on the cycle after the counter reaches `TIMEOUT_CYC`.
- **Pulse width:** `kb_valid` and `frame_err` are exactly one cycle and never assert in the same cycle.
- **Pin-to-edge latency:** input to filtered edge is 2 + `FILTER_LEN` cycles. Pulses shorter than `FILTER_LEN` cycles are ignored.
- **Timeout vs. edge:** if a timeout and a fall edge occur in the same cycle, the edge wins and the counter clears.
- **Reset mid-frame:** `clr` asserted mid-frame aborts immediately with no `frame_err` pulse. After release, the FSM waits for a new start bit.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: in STOP, the byte is good only if the stop bit is 1 and the 8 data bits plus the parity bit have odd parity. Otherwise `frame_err` pulses and the byte is dropped, with no decoder or flag update.
- Not defined: the parity bit is captured and ignored; only the stop bit is checked.

## Test plan
- Frame 1D (valid parity, 12 kHz `ps2c`) after reset → `kb_out`=1, one `kb_valid` pulse, `scan_code`=8'h1D, exactly 2 cycles after the filtered stop edge.
- Sequence E0 6B, then E0 F0 6B → `kb_out`=3 after the first make; `scan_code` steps E0, 6B, E0, F0, 6B; `kb_out` stays 3; a single `kb_valid` pulse in total.
- Byte 1D sent with a wrong parity bit → with `PS2_PARITY_CHECK_EN`: `frame_err` pulses, `kb_out` and `scan_code` unchanged. Without it: `kb_out`=1.
- Start bit plus 4 data bits, then `ps2c` held high for `TIMEOUT_CYC`+5 cycles → one `frame_err` pulse. A following 23 frame → `kb_out`=4.
- 3-cycle low glitches on `ps2c` while idle, and a stop bit of 0 on byte 29 → glitches produce no state change; the bad frame gives `frame_err`=1 for one cycle and `kb_out` unchanged.
- `clr` asserted during the 5th data bit of 29, then a full 29 frame → all outputs at reset values during `clr`; after release `kb_out`=5 and `kb_valid` pulses once.
